fifo_rr_arbiter: RTL
====================

Name: fifo_rr_arbiter

Overview:
- Controller that shares one 4-lane datapath between four input FIFOs and four output FIFOs of the architecture.
- Grants one non-empty input FIFO per cycle in round-robin order and pops it.
- Routes the popped word to the output FIFO selected by its two MSBs.
- Pauses all grants while any output FIFO is almost full; sits between the input FIFO bank and the output demux/FIFO bank.

Parameters:
DATA_W, 6, word width; bits [DATA_W-1:DATA_W-2] are the destination lane.
CNT_W, 8, width of the forwarded-word counter.

Ports:
clk  input  1  clock, all state updates on rising edge
reset_L  input  1  asynchronous active-low reset
init  input  1  forces INIT state while high
in_empty  input  4  empty flag per input FIFO (bit i = FIFO i)
in_data  input  4*DATA_W  read data per input FIFO, lane i at [i*DATA_W +: DATA_W], valid the cycle after pop[i]
out_almost_full  input  4  almost-full flag per output FIFO
pop  output  4  one-hot read strobe to input FIFOs
push  output  4  one-hot write strobe to output FIFOs
data_out  output  DATA_W  word written to output FIFOs
pause  output  1  high while grants are blocked by back-pressure
idle  output  1  high in IDLE state
fwd_count  output  CNT_W  total words pushed since reset, wraps modulo 2^CNT_W

Behaviour:
- All outputs are registered. Reset (asynchronous, reset_L=0) clears: pop=0, push=0, data_out=0, pause=0, idle=0, fwd_count=0, last_grant=3 (so lane 0 has first priority), in-flight flag=0, state=RESET.
- RESET -> INIT on the first edge with reset_L=1.
- INIT -> IDLE when init=0. Any state -> INIT when init=1; pop=0 while in INIT.
- IDLE: idle=1. On the first cycle with in_empty!=4'b1111 and init=0, go to ACTIVE; the first grant is issued in the same cycle.
- ACTIVE grant rule, evaluated every edge:
  - If any out_almost_full bit is 1: pause=1 on the next cycle and pop=0.
  - Otherwise pause=0. Search lanes last_grant+1, +2, +3, +4 (mod 4) and grant the first lane with in_empty=0.
  - For a grant: pop = one-hot of that lane for exactly one cycle; last_grant is updated.
  - No eligible lane: pop=0 and last_grant is unchanged.
- Datapath latency: pop[i] high in cycle t -> in cycle t+1 the arbiter samples in_data lane i.
  - In cycle t+2: data_out = that word, push = one-hot(word[DATA_W-1:DATA_W-2]), fwd_count increments by 1.
  - Back-to-back grants give one push per cycle, i.e. 2-cycle pop-to-push latency at full throughput.
- Up to 2 words may be in flight when pause rises, so output FIFOs must assert almost_full with at least 2 free entries. The arbiter never cancels an in-flight word.
- ACTIVE -> IDLE when in_empty=4'b1111 and no word is in flight; the last push completes before idle=1.
- init=1 during ACTIVE: no new pops; in-flight words are still pushed; then INIT.
- Reset mid-operation: in-flight words are dropped with no push, and all outputs clear immediately.
- Simultaneous events:
  - A lane going empty in the same cycle it would be granted is not granted; only the sampled in_empty is used.
  - pause and init both active: init wins.
- fwd_count wraps from 2^CNT_W-1 to 0 with no flag.
- push is never multi-hot, and pop is never multi-hot.

Test Plan:
1. Reset then init pulse, all in_empty=1111 -> state reaches IDLE, idle=1, pop=push=0, fwd_count=0.
2. Round-robin: all four FIFOs hold 2 words, out_almost_full=0 -> pop sequence 0001,0010,0100,1000,0001,0010,0100,1000 on consecutive cycles; 8 pushes, each 2 cycles after its pop; fwd_count=8; idle=1 afterwards.
3. Routing: FIFO 2 holds word 6'b11_0101 -> pop=0100, two cycles later push=1000, data_out=6'b110101.
4. Back-pressure: with all FIFOs non-empty, raise out_almost_full[1] for 5 cycles -> pause=1 and pop=0 during that window; in-flight words are still pushed; grants resume at lane last_grant+1.
5. Sparse requests: only FIFOs 1 and 3 non-empty with last_grant=1 -> pop alternates 1000,0010,1000,...; lanes 0 and 2 are never popped.
6. Reset mid-traffic: reset_L=0 one cycle after a pop -> push stays 0, fwd_count=0, all outputs 0 asynchronously; after release and init, lane 0 is granted first.

Source files
------------

// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: FIFO-bank signals shared by the round-robin arbiter
//   in_empty/in_data/pop        input FIFO bank (lane i at [i*DATA_W +: DATA_W])
//   out_almost_full/push/data_out  output FIFO bank
//   master = arbiter side, slave = FIFO bank side
interface fifo_rr_arbiter_if #(
    parameter int DATA_W = 6
) ();
    logic [3:0]          in_empty;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          out_almost_full;
    logic [3:0]          pop;
    logic [3:0]          push;
    logic [DATA_W-1:0]   data_out;
    modport master (input in_empty, in_data, out_almost_full, output pop, push, data_out);
    modport slave (output in_empty, in_data, out_almost_full, input pop, push, data_out);
endinterface

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin arbiter moving words from four input FIFOs to four output FIFOs
//   clk, reset_L  clock, asynchronous active-low reset
//   init          holds the arbiter in INIT while high
//   bus           master side of the FIFO bank interface (pop/push strobes, data_out)
//   pause         grants blocked by output back-pressure
//   idle          high in IDLE
//   fwd_count     words pushed since reset, wrapping
module fifo_rr_arbiter #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    fifo_rr_arbiter_if.master bus,
    output logic              pause,
    output logic              idle,
    output logic [CNT_W-1:0]  fwd_count
);
    typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE} state_t;
    state_t state, state_nx;
    logic [1:0] last_grant, last_nx, sel_lane;
    logic sel_v, busy, grant_en, pause_nx;
    logic [2:0] pick;
    logic [3:0] pop_nx;
    logic [DATA_W-1:0] word;
    // Offsets are walked far to near so the nearest non-empty lane after last wins.
    function automatic logic [2:0] rr_pick(input logic [1:0] last, input logic [3:0] empty);
        logic [2:0] r;
        logic [1:0] c;
        r = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            c = last + 2'(k);
            if (!empty[c]) r = {1'b1, c};
        end
        return r;
    endfunction
    // A word is in flight from its pop cycle until the cycle its in_data is sampled.
    assign busy = |bus.pop | sel_v;
    assign pick = rr_pick(last_grant, bus.in_empty);
    assign word = bus.in_data[sel_lane*DATA_W +: DATA_W];
    always_comb begin
        state_nx = state;
        case (state)
            S_RESET:  state_nx = S_INIT;
            S_INIT:   state_nx = S_IDLE;
            S_IDLE:   state_nx = &bus.in_empty ? S_IDLE : S_ACTIVE;
            S_ACTIVE: state_nx = (&bus.in_empty && !busy) ? S_IDLE : S_ACTIVE;
        endcase
        if (init) state_nx = S_INIT;
        grant_en = state_nx == S_ACTIVE;
        pause_nx = grant_en && |bus.out_almost_full;
        pop_nx   = (grant_en && !pause_nx && pick[2]) ? 4'b0001 << pick[1:0] : 4'b0000;
        last_nx  = |pop_nx ? pick[1:0] : last_grant;
    end
    // The datapath drains independently of the FSM, so init never cancels a popped word.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state        <= S_RESET;
            last_grant   <= 2'd3;
            bus.pop      <= 4'b0000;
            bus.push     <= 4'b0000;
            bus.data_out <= '0;
            pause        <= 1'b0;
            idle         <= 1'b0;
            sel_v        <= 1'b0;
            sel_lane     <= 2'd0;
            fwd_count    <= '0;
        end else begin
            state      <= state_nx;
            last_grant <= last_nx;
            bus.pop    <= pop_nx;
            pause      <= pause_nx;
            idle       <= state_nx == S_IDLE;
            sel_v      <= |bus.pop;
            sel_lane   <= {bus.pop[3] | bus.pop[2], bus.pop[3] | bus.pop[1]};
            bus.push   <= sel_v ? 4'b0001 << word[DATA_W-1 -: 2] : 4'b0000;
            if (sel_v) bus.data_out <= word;
            fwd_count  <= fwd_count + CNT_W'(sel_v);
        end
    end
endmodule
